// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg_pkg
// Purpose  : Shared mode encoding for the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_LOAD = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } mode_e;

endpackage : univ_shift_reg_pkg
`default_nettype wire

// File: rtl/usr_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : usr_frame_counter
// Purpose  : Counts shift steps modulo TERMINAL and pulses frame_done on wrap.
// Revision : 1.0 - initial release
// ============================================================================
module usr_frame_counter #(
    parameter int TERMINAL = 8,
    localparam int CNT_W   = $clog2(TERMINAL) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_frame_done;

    // A clearing LOAD outranks any step, so a load never produces a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (step) begin
                if (r_count == c_last_cnt) begin
                    r_count      <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign count      = r_count;
    assign frame_done = r_frame_done;

endmodule : usr_frame_counter
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Universal shift register (hold/shift/load/rotate) with frame
//            counter. Rotate modes enabled by macro UNIV_SHIFT_REG_ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    localparam int CNT_W = $clog2(WIDTH / LANES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic [LANES-1:0] sin_l,
    input  logic [LANES-1:0] sin_r,
    output logic [WIDTH-1:0] q,
    output logic [LANES-1:0] sout_l,
    output logic [LANES-1:0] sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    mode_e            w_mode;
    logic [WIDTH-1:0] w_q_next;
    logic             w_step;
    logic             w_clear;
    logic [WIDTH-1:0] r_q;

    assign w_mode = mode_e'(mode);

    // Reserved codes (and rotates when compiled out) fall to the hold default.
    always_comb begin
        w_q_next = r_q;
        w_step   = 1'b0;
        w_clear  = 1'b0;
        case (w_mode)
            MODE_SHL: begin
                w_q_next = {r_q[WIDTH-LANES-1:0], sin_l};
                w_step   = 1'b1;
            end
            MODE_SHR: begin
                w_q_next = {sin_r, r_q[WIDTH-1:LANES]};
                w_step   = 1'b1;
            end
            MODE_LOAD: begin
                w_q_next = pin;
                w_clear  = 1'b1;
            end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROTL: begin
                w_q_next = {r_q[WIDTH-LANES-1:0], r_q[WIDTH-1 -: LANES]};
                w_step   = 1'b1;
            end
            MODE_ROTR: begin
                w_q_next = {r_q[LANES-1:0], r_q[WIDTH-1:LANES]};
                w_step   = 1'b1;
            end
`endif
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    usr_frame_counter #(
        .TERMINAL (WIDTH / LANES)
    ) u_frame_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .step       (w_step),
        .count      (shift_cnt),
        .frame_done (frame_done)
    );

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1 -: LANES];
    assign sout_r = r_q[LANES-1:0];

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Directed self-checking bench for univ_shift_reg (8x1 and 8x2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [2:0] mode_a = 3'd0;
    logic [7:0] pin_a = 8'h00;
    logic [0:0] sin_l_a = 1'b0;
    logic [0:0] sin_r_a = 1'b0;
    logic [7:0] q_a;
    logic [0:0] sout_l_a;
    logic [0:0] sout_r_a;
    logic [3:0] cnt_a;
    logic       fd_a;

    logic [2:0] mode_b = 3'd0;
    logic [7:0] pin_b = 8'h00;
    logic [1:0] sin_l_b = 2'b00;
    logic [1:0] sin_r_b = 2'b00;
    logic [7:0] q_b;
    logic [1:0] sout_l_b;
    logic [1:0] sout_r_b;
    logic [2:0] cnt_b;
    logic       fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .LANES(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode_a),
        .pin        (pin_a),
        .sin_l      (sin_l_a),
        .sin_r      (sin_r_a),
        .q          (q_a),
        .sout_l     (sout_l_a),
        .sout_r     (sout_r_a),
        .shift_cnt  (cnt_a),
        .frame_done (fd_a)
    );

    univ_shift_reg #(.WIDTH(8), .LANES(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode_b),
        .pin        (pin_b),
        .sin_l      (sin_l_b),
        .sin_r      (sin_r_b),
        .q          (q_b),
        .sout_l     (sout_l_b),
        .sout_r     (sout_r_b),
        .shift_cnt  (cnt_b),
        .frame_done (fd_b)
    );

    // One operation on dut_a: present at negedge, sample 1ns after posedge, return mode to HOLD.
    task automatic op_a(input logic [2:0] m, input logic [7:0] p, input logic s);
        @(negedge clk);
        mode_a = m; pin_a = p; sin_l_a = s; sin_r_a = s;
        @(posedge clk);
        #1;
        mode_a = 3'd0;
    endtask

    task automatic op_b(input logic [2:0] m, input logic [7:0] p, input logic [1:0] s);
        @(negedge clk);
        mode_b = m; pin_b = p; sin_l_b = s; sin_r_b = s;
        @(posedge clk);
        #1;
        mode_b = 3'd0;
    endtask

    task automatic test_reset();
        n_cmp++; if (q_a !== 8'h00) begin n_bad++; $display("FAIL rst_q: got %h want 00", q_a); end
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", cnt_a); end
        n_cmp++; if (fd_a !== 1'b0) begin n_bad++; $display("FAIL rst_fd: got %b want 0", fd_a); end
        @(negedge clk);
        reset = 1'b0;
        op_a(3'd3, 8'hA5, 1'b0);
        op_a(3'd1, 8'h00, 1'b1);
        op_a(3'd1, 8'h00, 1'b1);
        n_cmp++; if (cnt_a !== 4'd2) begin n_bad++; $display("FAIL pre_rst_cnt: got %0d want 2", cnt_a); end
        // Assert reset between edges and look before any clock edge arrives.
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (q_a !== 8'h00) begin n_bad++; $display("FAIL async_q: got %h want 00", q_a); end
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL async_cnt: got %0d want 0", cnt_a); end
        n_cmp++; if ({sout_l_a, sout_r_a} !== 2'b00) begin n_bad++; $display("FAIL async_sout: got %b want 00", {sout_l_a, sout_r_a}); end
        // Reset held across an edge with LOAD presented must win.
        mode_a = 3'd3; pin_a = 8'hFF;
        @(posedge clk);
        #1;
        n_cmp++; if (q_a !== 8'h00) begin n_bad++; $display("FAIL rst_prio_q: got %h want 00", q_a); end
        @(negedge clk);
        mode_a = 3'd0;
        reset = 1'b0;
        op_a(3'd1, 8'h00, 1'b1);
        n_cmp++; if (cnt_a !== 4'd1) begin n_bad++; $display("FAIL post_rst_cnt: got %0d want 1", cnt_a); end
        n_cmp++; if (q_a !== 8'h01) begin n_bad++; $display("FAIL post_rst_q: got %h want 01", q_a); end
    endtask

    task automatic test_shl_frame();
        logic [7:0] pat;
        pat = 8'hA5;
        op_a(3'd3, 8'hA5, 1'b0);
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL load_cnt: got %0d want 0", cnt_a); end
        n_cmp++; if (fd_a !== 1'b0) begin n_bad++; $display("FAIL load_fd: got %b want 0", fd_a); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (sout_l_a !== pat[7-k]) begin n_bad++; $display("FAIL shl_sout_l[%0d]: got %b want %b", k, sout_l_a, pat[7-k]); end
            op_a(3'd1, 8'h00, 1'b0);
            n_cmp++; if (fd_a !== (k == 7)) begin n_bad++; $display("FAIL shl_fd[%0d]: got %b want %b", k, fd_a, (k == 7)); end
        end
        n_cmp++; if (q_a !== 8'h00) begin n_bad++; $display("FAIL shl_q: got %h want 00", q_a); end
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL shl_wrap_cnt: got %0d want 0", cnt_a); end
        op_a(3'd0, 8'h00, 1'b0);
        n_cmp++; if (fd_a !== 1'b0) begin n_bad++; $display("FAIL fd_one_cycle: got %b want 0", fd_a); end
    endtask

    task automatic test_shr();
        op_a(3'd3, 8'h81, 1'b0);
        op_a(3'd2, 8'h00, 1'b1);
        n_cmp++; if (q_a !== 8'hC0) begin n_bad++; $display("FAIL shr_q: got %h want c0", q_a); end
        n_cmp++; if (sout_r_a !== 1'b0) begin n_bad++; $display("FAIL shr_sout_r: got %b want 0", sout_r_a); end
        n_cmp++; if (cnt_a !== 4'd1) begin n_bad++; $display("FAIL shr_cnt: got %0d want 1", cnt_a); end
    endtask

    task automatic test_rotate();
        op_a(3'd3, 8'h81, 1'b0);
        op_a(3'd4, 8'h00, 1'b0);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        n_cmp++; if (q_a !== 8'h03) begin n_bad++; $display("FAIL rotl_q: got %h want 03", q_a); end
        n_cmp++; if (cnt_a !== 4'd1) begin n_bad++; $display("FAIL rotl_cnt: got %0d want 1", cnt_a); end
        op_a(3'd5, 8'h00, 1'b0);
        n_cmp++; if (q_a !== 8'h81) begin n_bad++; $display("FAIL rotr_q: got %h want 81", q_a); end
        n_cmp++; if (cnt_a !== 4'd2) begin n_bad++; $display("FAIL rotr_cnt: got %0d want 2", cnt_a); end
`else
        n_cmp++; if (q_a !== 8'h81) begin n_bad++; $display("FAIL rotl_off_q: got %h want 81", q_a); end
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL rotl_off_cnt: got %0d want 0", cnt_a); end
        op_a(3'd5, 8'h00, 1'b0);
        n_cmp++; if (q_a !== 8'h81) begin n_bad++; $display("FAIL rotr_off_q: got %h want 81", q_a); end
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL rotr_off_cnt: got %0d want 0", cnt_a); end
`endif
    endtask

    task automatic test_lanes2();
        logic [7:0] exp_q [4];
        exp_q = '{8'h6F, 8'hBC, 8'hF0, 8'hC0};
        op_b(3'd3, 8'h1B, 2'b00);
        for (int k = 0; k < 4; k++) begin
            op_b(3'd1, 8'h00, (k == 0) ? 2'b11 : 2'b00);
            n_cmp++; if (q_b !== exp_q[k]) begin n_bad++; $display("FAIL l2_q[%0d]: got %h want %h", k, q_b, exp_q[k]); end
            n_cmp++; if (fd_b !== (k == 3)) begin n_bad++; $display("FAIL l2_fd[%0d]: got %b want %b", k, fd_b, (k == 3)); end
            if (k == 0) begin
                n_cmp++; if (sout_l_b !== 2'b01) begin n_bad++; $display("FAIL l2_sout_l: got %b want 01", sout_l_b); end
                n_cmp++; if (cnt_b !== 3'd1) begin n_bad++; $display("FAIL l2_cnt: got %0d want 1", cnt_b); end
            end
        end
        n_cmp++; if (cnt_b !== 3'd0) begin n_bad++; $display("FAIL l2_wrap_cnt: got %0d want 0", cnt_b); end
    endtask

    task automatic test_load_mid_and_reserved();
        op_a(3'd3, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) op_a(3'd1, 8'h00, 1'b1);
        n_cmp++; if (cnt_a !== 4'd5) begin n_bad++; $display("FAIL mid_cnt: got %0d want 5", cnt_a); end
        op_a(3'd3, 8'hFF, 1'b0);
        n_cmp++; if (cnt_a !== 4'd0) begin n_bad++; $display("FAIL mid_load_cnt: got %0d want 0", cnt_a); end
        n_cmp++; if (fd_a !== 1'b0) begin n_bad++; $display("FAIL mid_load_fd: got %b want 0", fd_a); end
        op_a(3'd6, 8'h00, 1'b0);
        n_cmp++; if ({q_a, cnt_a} !== {8'hFF, 4'd0}) begin n_bad++; $display("FAIL mode6: got %h/%0d want ff/0", q_a, cnt_a); end
        op_a(3'd7, 8'h00, 1'b0);
        n_cmp++; if ({q_a, cnt_a} !== {8'hFF, 4'd0}) begin n_bad++; $display("FAIL mode7: got %h/%0d want ff/0", q_a, cnt_a); end
        op_a(3'd1, 8'h00, 1'b0);
        op_a(3'd0, 8'h00, 1'b1);
        n_cmp++; if ({q_a, cnt_a} !== {8'hFE, 4'd1}) begin n_bad++; $display("FAIL hold: got %h/%0d want fe/1", q_a, cnt_a); end
        for (int k = 1; k < 8; k++) begin
            op_a(3'd1, 8'h00, 1'b1);
            n_cmp++; if (fd_a !== (k == 7)) begin n_bad++; $display("FAIL mid_fd[%0d]: got %b want %b", k, fd_a, (k == 7)); end
        end
    endtask

    task automatic test_back_to_back();
        op_a(3'd3, 8'h3C, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            op_a(3'd2, 8'h00, k[0]);
            n_cmp++; if (fd_a !== (k == 8 || k == 16)) begin n_bad++; $display("FAIL b2b_fd[%0d]: got %b want %b", k, fd_a, (k == 8 || k == 16)); end
        end
        // Last 8 SHR inputs alternate 1,0,...,0 from MSB side: final q = 0b01010101.
        n_cmp++; if (q_a !== 8'h55) begin n_bad++; $display("FAIL b2b_q: got %h want 55", q_a); end
    endtask

    initial begin
        #23;
        test_reset();
        test_shl_frame();
        test_shr();
        test_rotate();
        test_lanes2();
        test_load_mid_and_reserved();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_univ_shift_reg
`default_nettype wire
